// File: rtl/reg_file_pkg.sv
// Shared sizing helpers and byte-lane merge for the register file and its read ports.
// Merge operates on the widest supported word; callers zero-extend in and truncate out.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic int calc_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int calc_be_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] new_v,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] r;
    r = old_v;
    for (int k = 0; k < MAX_BE_W; k++) begin
      if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: address mux, same-cycle write forwarding, optional output register.
// Latency 0 (READ_REG=0) or 1 cycle (READ_REG=1); never stalls.
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int ADDR_W   = DEF_ADDR_W,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  parameter  int READ_REG = 0,
  localparam int DEPTH    = calc_depth(ADDR_W),
  localparam int BE_W     = calc_be_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] regs_i [DEPTH],
  input  logic [DEPTH-1:0]  busy_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [BE_W-1:0]   wr_be_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_busy_o
);

  logic [DATA_W-1:0] sel_data;
  logic              sel_busy;
  logic              is_zero;
  logic              hit;

  always_comb begin
    is_zero  = (ZERO_REG != 0) && (rd_addr_i == '0);
    hit      = (BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i) && !is_zero;
    sel_data = regs_i[rd_addr_i];
    sel_busy = busy_i[rd_addr_i];
    if (hit) begin
      sel_data = DATA_W'(merge_bytes(MAX_DATA_W'(regs_i[rd_addr_i]),
                                     MAX_DATA_W'(wr_data_i),
                                     MAX_BE_W'(wr_be_i)));
      sel_busy = 1'b0;
    end
    if (is_zero) begin
      sel_data = '0;
      sel_busy = 1'b0;
    end
  end

  if (READ_REG != 0) begin : g_reg
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_busy_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_data_q <= '0;
        rd_busy_q <= 1'b0;
      end else begin
        rd_data_q <= sel_data;
        rd_busy_q <= sel_busy;
      end
    end
    assign rd_data_o = rd_data_q;
    assign rd_busy_o = rd_busy_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign rd_data_o = sel_data;
    assign rd_busy_o = sel_busy;
  end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file with byte-enable write, two read ports, per-register busy scoreboard,
// busy counter and an addressed debug read port (always combinational, never forwarded).
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int ADDR_W   = DEF_ADDR_W,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  parameter  int READ_REG = 0,
  localparam int DEPTH    = calc_depth(ADDR_W),
  localparam int BE_W     = calc_be_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [BE_W-1:0]   wr_be_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              alloc_en_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_1_i,
  input  logic [ADDR_W-1:0] rd_addr_2_i,
  output logic [DATA_W-1:0] rd_data_1_o,
  output logic [DATA_W-1:0] rd_data_2_o,
  output logic              rd_busy_1_o,
  output logic              rd_busy_2_o,
  output logic [ADDR_W:0]   busy_cnt_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_ok, al_ok, inc, dec;

  always_comb begin
    wr_ok = wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == '0));
    al_ok = alloc_en_i && !((ZERO_REG != 0) && (alloc_addr_i == '0));
    // A same-index alloc keeps the register busy, so the writeback must not decrement.
    inc   = al_ok && !busy_q[alloc_addr_i];
    dec   = wr_ok && busy_q[wr_addr_i] && !(al_ok && (alloc_addr_i == wr_addr_i));
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[wr_addr_i] = DATA_W'(merge_bytes(MAX_DATA_W'(regs_q[wr_addr_i]),
                                              MAX_DATA_W'(wr_data_i),
                                              MAX_BE_W'(wr_be_i)));
      busy_d[wr_addr_i] = 1'b0;
    end
    if (al_ok) busy_d[alloc_addr_i] = 1'b1;
    cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt_o = cnt_q;
  assign dbg_data_o = regs_q[dbg_addr_i];

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS), .READ_REG(READ_REG)
  ) u_rd_1 (
    .clk(clk), .reset(reset), .regs_i(regs_q), .busy_i(busy_q),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_be_i(wr_be_i), .wr_data_i(wr_data_i),
    .rd_addr_i(rd_addr_1_i), .rd_data_o(rd_data_1_o), .rd_busy_o(rd_busy_1_o)
  );

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS), .READ_REG(READ_REG)
  ) u_rd_2 (
    .clk(clk), .reset(reset), .regs_i(regs_q), .busy_i(busy_q),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_be_i(wr_be_i), .wr_data_i(wr_data_i),
    .rd_addr_i(rd_addr_2_i), .rd_data_o(rd_data_2_o), .rd_busy_o(rd_busy_2_o)
  );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Three configurations share one stimulus stream: A = bypass/comb, B = no bypass/comb,
// C = bypass/registered reads. An array-based model supplies all expected values.
module tb_reg_file_scoreboard;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en, alloc_en;
  logic [4:0]  wr_addr, alloc_addr, rd_addr_1, rd_addr_2, dbg_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  logic [31:0] a_rd1, a_rd2, a_dbg, b_rd1, b_rd2, b_dbg, c_rd1, c_rd2, c_dbg;
  logic        a_bz1, a_bz2, b_bz1, b_bz2, c_bz1, c_bz2;
  logic [5:0]  a_cnt, b_cnt, c_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_reg [32];
  bit          m_busy [32];

  reg_file_scoreboard #(.BYPASS(1), .READ_REG(0)) u_a (
    .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
    .wr_data_i(wr_data), .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
    .rd_addr_1_i(rd_addr_1), .rd_addr_2_i(rd_addr_2), .rd_data_1_o(a_rd1), .rd_data_2_o(a_rd2),
    .rd_busy_1_o(a_bz1), .rd_busy_2_o(a_bz2), .busy_cnt_o(a_cnt), .dbg_addr_i(dbg_addr),
    .dbg_data_o(a_dbg));

  reg_file_scoreboard #(.BYPASS(0), .READ_REG(0)) u_b (
    .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
    .wr_data_i(wr_data), .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
    .rd_addr_1_i(rd_addr_1), .rd_addr_2_i(rd_addr_2), .rd_data_1_o(b_rd1), .rd_data_2_o(b_rd2),
    .rd_busy_1_o(b_bz1), .rd_busy_2_o(b_bz2), .busy_cnt_o(b_cnt), .dbg_addr_i(dbg_addr),
    .dbg_data_o(b_dbg));

  reg_file_scoreboard #(.BYPASS(1), .READ_REG(1)) u_c (
    .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
    .wr_data_i(wr_data), .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
    .rd_addr_1_i(rd_addr_1), .rd_addr_2_i(rd_addr_2), .rd_data_1_o(c_rd1), .rd_data_2_o(c_rd2),
    .rd_busy_1_o(c_bz1), .rd_busy_2_o(c_bz2), .busy_cnt_o(c_cnt), .dbg_addr_i(dbg_addr),
    .dbg_data_o(c_dbg));

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = m_reg[a];
    if (byp && wr_en && wr_addr == a)
      for (int k = 0; k < 4; k++) if (wr_be[k]) v[8*k +: 8] = wr_data[8*k +: 8];
    return v;
  endfunction

  function automatic bit exp_busy(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp && wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_update();
    if (wr_en && wr_addr != 5'd0) begin
      for (int k = 0; k < 4; k++) if (wr_be[k]) m_reg[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
      m_busy[wr_addr] = 1'b0;
    end
    if (alloc_en && alloc_addr != 5'd0) m_busy[alloc_addr] = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'd0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = 5'd0; wr_be = 4'd0; wr_data = 32'd0;
    alloc_en = 1'b0; alloc_addr = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic test_reset();
    idle();
    rd_addr_1 = 5'd0; rd_addr_2 = 5'd0; dbg_addr = 5'd0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (a_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", a_cnt); end
    checks++; if (c_rd1 !== 32'd0 || c_bz1 !== 1'b0) begin errors++; $display("FAIL reset_regout: got %h/%b expected 0/0", c_rd1, c_bz1); end
    reset = 1'b1;
  endtask

  task automatic test_async_reset();
    do_write(5'd5, 32'h1111_2222, 4'hF); alloc_en = 1'b1; alloc_addr = 5'd9; tick();
    do_write(5'd9, 32'h0000_3333, 4'hF); alloc_en = 1'b1; alloc_addr = 5'd5; tick();
    idle(); dbg_addr = 5'd5; #2;
    checks++; if (a_dbg !== 32'h1111_2222) begin errors++; $display("FAIL prereset_r5: got %h expected 11112222", a_dbg); end
    checks++; if (a_cnt !== 6'd1) begin errors++; $display("FAIL prereset_cnt: got %0d expected 1", a_cnt); end
    #1 reset = 1'b0;
    model_reset();
    #1;
    checks++; if (a_cnt !== 6'd0 || c_cnt !== 6'd0) begin errors++; $display("FAIL async_cnt: got %0d/%0d expected 0", a_cnt, c_cnt); end
    for (int i = 0; i < 32; i++) begin
      rd_addr_1 = 5'(i); rd_addr_2 = 5'(i); dbg_addr = 5'(i); #1;
      checks++;
      if (a_rd1 !== 32'd0 || a_bz1 !== 1'b0 || a_dbg !== 32'd0 || c_rd2 !== 32'd0) begin
        errors++; $display("FAIL async_r%0d: got %h/%b/%h/%h expected all 0", i, a_rd1, a_bz1, a_dbg, c_rd2);
      end
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_byte_write();
    do_write(5'd3, 32'hDEAD_BEEF, 4'b1111); tick();
    do_write(5'd3, 32'h0000_00AA, 4'b0001); tick();
    idle(); rd_addr_1 = 5'd3; dbg_addr = 5'd3; #2;
    checks++; if (a_rd1 !== 32'hDEAD_BEAA) begin errors++; $display("FAIL bytewr_a: got %h expected deadbeaa", a_rd1); end
    checks++; if (b_rd1 !== 32'hDEAD_BEAA) begin errors++; $display("FAIL bytewr_b: got %h expected deadbeaa", b_rd1); end
    checks++; if (a_dbg !== 32'hDEAD_BEAA) begin errors++; $display("FAIL bytewr_dbg: got %h expected deadbeaa", a_dbg); end
    tick();
    checks++; if (c_rd1 !== 32'hDEAD_BEAA) begin errors++; $display("FAIL bytewr_c: got %h expected deadbeaa", c_rd1); end
  endtask

  task automatic test_bypass();
    do_write(5'd7, 32'h1234_5678, 4'hF); rd_addr_1 = 5'd7; rd_addr_2 = 5'd7; dbg_addr = 5'd7; #2;
    checks++; if (a_rd1 !== 32'h1234_5678 || a_rd2 !== 32'h1234_5678) begin errors++; $display("FAIL bypass_a: got %h/%h expected 12345678", a_rd1, a_rd2); end
    checks++; if (b_rd1 !== 32'd0) begin errors++; $display("FAIL nobypass_b: got %h expected 0", b_rd1); end
    checks++; if (a_dbg !== 32'd0) begin errors++; $display("FAIL bypass_dbg: got %h expected 0", a_dbg); end
    tick();
    do_write(5'd7, 32'hAABB_CCDD, 4'b0010); #2;
    checks++; if (a_rd1 !== 32'h1234_CC78) begin errors++; $display("FAIL bypass_merge: got %h expected 1234cc78", a_rd1); end
    checks++; if (b_rd2 !== 32'h1234_5678) begin errors++; $display("FAIL nobypass_old: got %h expected 12345678", b_rd2); end
    tick(); idle();
  endtask

  task automatic test_scoreboard();
    alloc_en = 1'b1; alloc_addr = 5'd4; tick();
    checks++; if (a_cnt !== 6'd1) begin errors++; $display("FAIL cnt_alloc1: got %0d expected 1", a_cnt); end
    alloc_addr = 5'd6; tick();
    checks++; if (a_cnt !== 6'd2) begin errors++; $display("FAIL cnt_alloc2: got %0d expected 2", a_cnt); end
    alloc_addr = 5'd8; do_write(5'd4, 32'hCAFE_0004, 4'hF); rd_addr_1 = 5'd4; #2;
    checks++; if (a_bz1 !== 1'b0 || b_bz1 !== 1'b1) begin errors++; $display("FAIL busy_bypass: got %b/%b expected 0/1", a_bz1, b_bz1); end
    tick(); idle(); rd_addr_1 = 5'd4; rd_addr_2 = 5'd8; #2;
    checks++; if (a_cnt !== 6'd2) begin errors++; $display("FAIL cnt_swap: got %0d expected 2", a_cnt); end
    checks++; if (a_bz1 !== 1'b0 || a_bz2 !== 1'b1) begin errors++; $display("FAIL busy_swap: got %b/%b expected 0/1", a_bz1, a_bz2); end
    alloc_en = 1'b1; alloc_addr = 5'd10; do_write(5'd10, 32'h0000_0055, 4'hF); tick();
    idle(); rd_addr_1 = 5'd10; #2;
    checks++; if (a_bz1 !== 1'b1 || a_rd1 !== 32'h55 || a_cnt !== 6'd3) begin errors++; $display("FAIL alloc_wr_same: got %b/%h/%0d expected 1/55/3", a_bz1, a_rd1, a_cnt); end
    alloc_en = 1'b1; alloc_addr = 5'd6; tick();
    checks++; if (a_cnt !== 6'd3) begin errors++; $display("FAIL realloc: got %0d expected 3", a_cnt); end
    idle(); do_write(5'd12, 32'h0BAD_0BAD, 4'hF); tick();
    checks++; if (a_cnt !== 6'd3) begin errors++; $display("FAIL wr_notbusy: got %0d expected 3", a_cnt); end
    idle(); alloc_en = 1'b1; alloc_addr = 5'd14; rd_addr_1 = 5'd14; #2;
    checks++; if (a_bz1 !== 1'b0) begin errors++; $display("FAIL alloc_same_cycle: got %b expected 0", a_bz1); end
    tick(); idle(); #2;
    checks++; if (a_bz1 !== 1'b1 || a_cnt !== 6'd4) begin errors++; $display("FAIL alloc_next: got %b/%0d expected 1/4", a_bz1, a_cnt); end
  endtask

  task automatic test_zero_reg();
    do_write(5'd0, 32'hFFFF_FFFF, 4'hF); alloc_en = 1'b1; alloc_addr = 5'd0;
    rd_addr_1 = 5'd0; rd_addr_2 = 5'd0; dbg_addr = 5'd0; #2;
    checks++; if (a_rd1 !== 32'd0 || a_bz1 !== 1'b0) begin errors++; $display("FAIL zero_bypass: got %h/%b expected 0/0", a_rd1, a_bz1); end
    tick(); idle(); #2;
    checks++; if (a_rd2 !== 32'd0 || a_dbg !== 32'd0 || a_cnt !== 6'd4) begin errors++; $display("FAIL zero_after: got %h/%h/%0d expected 0/0/4", a_rd2, a_dbg, a_cnt); end
    checks++; if (c_rd1 !== 32'd0 || c_bz1 !== 1'b0) begin errors++; $display("FAIL zero_reg_c: got %h/%b expected 0/0", c_rd1, c_bz1); end
  endtask

  task automatic test_read_latency();
    idle(); rd_addr_1 = 5'd12; tick();
    rd_addr_1 = 5'd3; #2;
    checks++; if (c_rd1 !== 32'h0BAD_0BAD) begin errors++; $display("FAIL latency_hold: got %h expected 0bad0bad", c_rd1); end
    checks++; if (a_rd1 !== 32'hDEAD_BEAA) begin errors++; $display("FAIL latency_comb: got %h expected deadbeaa", a_rd1); end
    tick();
    checks++; if (c_rd1 !== 32'hDEAD_BEAA) begin errors++; $display("FAIL latency_next: got %h expected deadbeaa", c_rd1); end
  endtask

  task automatic test_random();
    logic [31:0] ed1, ed2;
    bit          eb1, eb2;
    for (int n = 0; n < 400; n++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = 5'($urandom_range(0, 15));
      wr_be = 4'($urandom); wr_data = $urandom;
      alloc_en = 1'($urandom_range(0, 1)); alloc_addr = 5'($urandom_range(0, 15));
      rd_addr_1 = 5'($urandom_range(0, 15)); rd_addr_2 = 5'($urandom_range(0, 15));
      dbg_addr = 5'($urandom_range(0, 15));
      #2;
      ed1 = exp_data(rd_addr_1, 1'b1); ed2 = exp_data(rd_addr_2, 1'b1);
      eb1 = exp_busy(rd_addr_1, 1'b1); eb2 = exp_busy(rd_addr_2, 1'b1);
      checks++; if (a_rd1 !== ed1 || a_rd2 !== ed2) begin errors++; $display("FAIL rnd_a_data[%0d]: got %h/%h expected %h/%h", n, a_rd1, a_rd2, ed1, ed2); end
      checks++; if (a_bz1 !== eb1 || a_bz2 !== eb2) begin errors++; $display("FAIL rnd_a_busy[%0d]: got %b/%b expected %b/%b", n, a_bz1, a_bz2, eb1, eb2); end
      checks++; if (b_rd1 !== exp_data(rd_addr_1, 1'b0) || b_bz2 !== exp_busy(rd_addr_2, 1'b0)) begin
        errors++; $display("FAIL rnd_b[%0d]: got %h/%b expected %h/%b", n, b_rd1, b_bz2, exp_data(rd_addr_1, 1'b0), exp_busy(rd_addr_2, 1'b0)); end
      checks++; if (a_dbg !== exp_data(dbg_addr, 1'b0)) begin errors++; $display("FAIL rnd_dbg[%0d]: got %h expected %h", n, a_dbg, exp_data(dbg_addr, 1'b0)); end
      checks++; if (int'(a_cnt) != model_cnt()) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", n, a_cnt, model_cnt()); end
      @(posedge clk);
      model_update();
      #1;
      checks++; if (c_rd1 !== ed1 || c_rd2 !== ed2 || c_bz1 !== eb1 || c_bz2 !== eb2) begin
        errors++; $display("FAIL rnd_c[%0d]: got %h/%h/%b/%b expected %h/%h/%b/%b", n, c_rd1, c_rd2, c_bz1, c_bz2, ed1, ed2, eb1, eb2); end
      checks++; if (int'(c_cnt) != model_cnt() || int'(b_cnt) != model_cnt()) begin
        errors++; $display("FAIL rnd_cnt_post[%0d]: got %0d/%0d expected %0d", n, c_cnt, b_cnt, model_cnt()); end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_byte_write();
    test_bypass();
    test_scoreboard();
    test_zero_reg();
    test_read_latency();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
Parametrised next-generation register file: 1 write port with byte enables, 2 read ports, optional write-to-read bypass and optional registered reads.
Adds a per-register busy scoreboard for pipeline hazard detection: set on destination allocation, cleared on writeback.
Adds a busy-count counter.
Replaces the 32 flat Q debug outputs with one addressed debug read port.
Sits between the decode/issue stage (read, alloc) and the writeback stage (write) of the CPU datapath.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
ZERO_REG, 1, 1 = register 0 is hardwired to zero.
BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads.
READ_REG, 0, 0 = combinational reads; 1 = read data/busy registered (1-cycle latency).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
wr_en_i  input  1  write enable (writeback).
wr_addr_i  input  ADDR_W  write register index.
wr_be_i  input  DATA_W/8  byte-lane write enables.
wr_data_i  input  DATA_W  write data.
alloc_en_i  input  1  mark the destination register busy (issue).
alloc_addr_i  input  ADDR_W  register index to allocate.
rd_addr_1_i  input  ADDR_W  read port 1 index (rs).
rd_addr_2_i  input  ADDR_W  read port 2 index (rt).
rd_data_1_o  output  DATA_W  port 1 read data.
rd_data_2_o  output  DATA_W  port 2 read data.
rd_busy_1_o  output  1  port 1 register has a pending write.
rd_busy_2_o  output  1  port 2 register has a pending write.
busy_cnt_o  output  ADDR_W+1  number of currently busy registers.
dbg_addr_i  input  ADDR_W  debug read index.
dbg_data_o  output  DATA_W  debug read data; always combinational, never bypassed.

Behaviour:
- Reset (reset low, asynchronous):
  - All registers 0, all busy bits 0, busy_cnt_o 0.
  - With READ_REG=1, the rd_data/rd_busy output registers are 0.
  - Reset release is synchronous to clk (2-flop release handled at top level; not in this block).
- Write: at posedge with wr_en_i=1, each byte lane k with wr_be_i[k]=1 takes wr_data_i[8k+7:8k]; the other lanes hold.
  - wr_en_i=1 with wr_be_i=0 writes no data but still clears busy.
- ZERO_REG=1:
  - Writes and allocs to index 0 are ignored.
  - Reads of index 0 return 0 with busy 0, including under bypass.
- Read, READ_REG=0: rd_data_x_o = reg[rd_addr_x_i] combinationally.
  - If BYPASS=1, wr_en_i=1 and wr_addr_i==rd_addr_x_i (not a ZERO_REG index 0): output the merged value (enabled lanes from wr_data_i, the rest from the stored value).
  - BYPASS=0: the pre-write value.
- Read, READ_REG=1: the same selection (merged or pre-write) is registered at posedge; latency 1 cycle; outputs always update (no enable).
- Scoreboard: busy[a] is set at posedge when alloc_en_i=1 and alloc_addr_i=a; it is cleared at posedge when wr_en_i=1 and wr_addr_i=a.
  - Alloc and write to the same index in the same cycle: set wins; busy stays 1 (new producer issued).
  - Alloc to an already-busy register: busy stays 1; count unchanged.
  - Write to a non-busy register: busy stays 0; count unchanged.
- rd_busy_x_o = busy[rd_addr_x_i], except when BYPASS=1 and a same-cycle write hits that index, then 0.
  - A same-cycle alloc is not reflected until the next cycle.
  - Registered alongside the data when READ_REG=1.
- busy_cnt_o: registered. Next value = current + (alloc sets a 0-bit) - (write clears a 1-bit), evaluated per cycle. Set and clear of different indices in the same cycle leaves it unchanged. Range 0..DEPTH (or DEPTH-1 with ZERO_REG); it can never wrap.
- Both read ports are fully independent; identical addresses return identical data and busy.

Decomposition:
- reg_file_pkg holds:
  - default DATA_W and ADDR_W;
  - the function computing DEPTH and BE_W = DATA_W/8;
  - the merge_bytes(old, new, be) function shared by the write path and the bypass.
- Sub-module rf_read_port (address mux, bypass compare/merge, optional output register) is instantiated twice. The register array, scoreboard and counter stay in the top.

Test Plan:
- Reset low mid-run after writes to r5, r9 -> rd_data of all indices 0, busy 0, busy_cnt_o 0 immediately (asynchronous).
- Write r3=0xDEADBEEF, be=4'b1111; next cycle write r3=0x000000AA, be=4'b0001 -> read r3 = 0xDEADBEAA; dbg_addr_i=3 gives the same.
- BYPASS=1, READ_REG=0: write r7=0x12345678 while reading r7 in the same cycle -> rd_data_1_o=0x12345678 that cycle. With BYPASS=0 -> old value 0.
- Alloc r4, r6 in consecutive cycles -> busy_cnt_o 1 then 2. Then alloc r8 + write r4 in the same cycle -> count stays 2, r4 busy 0, r8 busy 1.
- Alloc r10 and write r10 in the same cycle -> r10 busy 1 afterwards; data updated; count +1.
- ZERO_REG=1: write r0=0xFFFFFFFF, alloc r0 -> read r0 = 0, busy 0, count unchanged. READ_REG=1 -> every read result appears exactly 1 cycle after its address.
